// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU row buffer constants and types
// Contents: ROW_WIDTH (visible pixels per row), ROWRAM_ADDR_W (row RAM address
// width), PIXEL_W (pixel width), pixel_t, rowbuf_state_t (writer FSM states).
package ppu_pkg;

  localparam int ROW_WIDTH     = 320;
  localparam int ROWRAM_ADDR_W = 9;
  localparam int PIXEL_W       = 10;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } rowbuf_state_t;

endpackage

// File: rtl/ppu_rowbuf_writer_if.sv
// rtl/ppu_rowbuf_writer_if.sv - mixer stream, status and HDMI read bundle for the row buffer
// slave modport (writer side):
//   in : pix_data, pix_valid, underrun_clr, rowram_swap, rowram_rdaddr
//   out: pix_ready, row_start, row_done, underrun, rowram_rddata
// master modport is the mirror (mixer + HDMI output side).
interface ppu_rowbuf_writer_if #(
  parameter int DATA_W = ppu_pkg::PIXEL_W,
  parameter int ADDR_W = ppu_pkg::ROWRAM_ADDR_W
);

  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              row_start;
  logic              row_done;
  logic              underrun;
  logic              underrun_clr;
  logic              rowram_swap;
  logic [ADDR_W-1:0] rowram_rdaddr;
  logic [DATA_W-1:0] rowram_rddata;

  modport slave (
    input  pix_data, pix_valid, underrun_clr, rowram_swap, rowram_rdaddr,
    output pix_ready, row_start, row_done, underrun, rowram_rddata
  );

  modport master (
    output pix_data, pix_valid, underrun_clr, rowram_swap, rowram_rdaddr,
    input  pix_ready, row_start, row_done, underrun, rowram_rddata
  );

endinterface

// File: rtl/row_ram.sv
// rtl/row_ram.sv - simple dual-port row RAM: port A registered read, port B write
// Ports: clk; a_addr -> a_rddata (1-cycle latency); b_we/b_addr/b_wrdata write.
// Contents are not reset.
module row_ram #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_rddata,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wrdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    a_rddata <= mem[a_addr];
    if (b_we) begin
      mem[b_addr] <= b_wrdata;
    end
  end

endmodule

// File: rtl/ppu_rowbuf_writer.sv
// rtl/ppu_rowbuf_writer.sv - double-buffered PPU row RAM: mixer fills back bank, HDMI reads front
// Ports: clk, rst_n (async, active-low); bus (ppu_rowbuf_writer_if.slave):
//   pixel stream in (pix_data/pix_valid/pix_ready), row_start/row_done pulses,
//   sticky underrun with underrun_clr, rowram_swap pulse, front-bank read
//   (rowram_rdaddr -> rowram_rddata, 1-cycle latency).
module ppu_rowbuf_writer #(
  parameter int ROW_WIDTH = ppu_pkg::ROW_WIDTH,
  parameter int DATA_W    = ppu_pkg::PIXEL_W,
  parameter int ADDR_W    = ppu_pkg::ROWRAM_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  ppu_rowbuf_writer_if.slave  bus
);

  import ppu_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_X    = ADDR_W'(ROW_WIDTH - 1);
  localparam logic [ADDR_W:0]   ROW_LIMIT = (ADDR_W + 1)'(ROW_WIDTH);

  rowbuf_state_t     state, state_nxt;
  logic [ADDR_W-1:0] wr_x, wr_x_nxt;
  logic              front_sel;
  logic              row_start_q, row_done_q, row_done_nxt;
  logic              underrun_q, underrun_set;
  logic              accept, last_accept;
  logic              rd_sel, rd_inrange;
  logic [DATA_W-1:0] bank0_q, bank1_q;

  assign accept      = bus.pix_valid && (state == FILL);
  assign last_accept = accept && (wr_x == LAST_X);

  always_comb begin
    state_nxt    = state;
    wr_x_nxt     = wr_x;
    row_done_nxt = 1'b0;
    underrun_set = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (wr_x == LAST_X) begin
            wr_x_nxt     = '0;
            state_nxt    = FULL;
            row_done_nxt = 1'b1;
          end else begin
            wr_x_nxt = wr_x + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
    // A swap overrides everything; a completing accept in the same cycle
    // still counts as a full row, so it is not an underrun.
    if (bus.rowram_swap) begin
      state_nxt    = FILL;
      wr_x_nxt     = '0;
      underrun_set = (state == FILL) && !last_accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_x        <= '0;
      front_sel   <= 1'b0;
      row_start_q <= 1'b0;
      row_done_q  <= 1'b0;
      underrun_q  <= 1'b0;
      rd_sel      <= 1'b0;
      rd_inrange  <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_x        <= wr_x_nxt;
      front_sel   <= front_sel ^ bus.rowram_swap;
      row_start_q <= bus.rowram_swap;
      row_done_q  <= row_done_nxt;
      underrun_q  <= underrun_set | (underrun_q & ~bus.underrun_clr);
      // Bank select and range captured with the address, so a read issued
      // in the swap cycle still sees the pre-swap front bank.
      rd_sel      <= front_sel;
      rd_inrange  <= ({1'b0, bus.rowram_rdaddr} < ROW_LIMIT);
    end
  end

  // Back bank is ~front_sel; the write in a swap cycle uses the old select.
  row_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk      (clk),
    .a_addr   (bus.rowram_rdaddr),
    .a_rddata (bank0_q),
    .b_we     (accept && front_sel),
    .b_addr   (wr_x),
    .b_wrdata (bus.pix_data)
  );

  row_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk      (clk),
    .a_addr   (bus.rowram_rdaddr),
    .a_rddata (bank1_q),
    .b_we     (accept && !front_sel),
    .b_addr   (wr_x),
    .b_wrdata (bus.pix_data)
  );

  // rd_inrange resets low, which also masks unreset RAM output after reset.
  assign bus.rowram_rddata = rd_inrange ? (rd_sel ? bank1_q : bank0_q) : '0;
  assign bus.pix_ready     = (state == FILL);
  assign bus.row_start     = row_start_q;
  assign bus.row_done      = row_done_q;
  assign bus.underrun      = underrun_q;

endmodule
